// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, instruction
// classes, immediate formats and register-usage helpers.
package decode_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      OC_OP     = 4'd0,
      OC_OP_IMM = 4'd1,
      OC_LOAD   = 4'd2,
      OC_STORE  = 4'd3,
      OC_BRANCH = 4'd4,
      OC_JAL    = 4'd5,
      OC_JALR   = 4'd6,
      OC_LUI    = 4'd7,
      OC_AUIPC  = 4'd8
   } opclass_t;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } imm_fmt_t;

   function automatic logic uses_rs1(input opclass_t oc);
      return oc inside {OC_OP, OC_OP_IMM, OC_LOAD, OC_STORE, OC_BRANCH, OC_JALR};
   endfunction

   function automatic logic uses_rs2(input opclass_t oc);
      return oc inside {OC_OP, OC_STORE, OC_BRANCH};
   endfunction

   // Class-level answer only; the caller still has to exclude rd == x0.
   function automatic logic writes_rd(input opclass_t oc);
      return oc inside {OC_OP, OC_OP_IMM, OC_LOAD, OC_JAL, OC_JALR, OC_LUI, OC_AUIPC};
   endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator. The opcode bits are not needed,
// so only instr[31:7] comes in.
module imm_gen
   import decode_pkg::*;
(
   input  logic [31:7] instr,
   input  imm_fmt_t    fmt,
   output logic [31:0] imm
);

   // Reassemble and sign-extend the immediate for the selected format.
   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'h000};
         FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: holds one instruction in ID, reads operands from the
// register bank, and issues a registered bundle to execute. A busy bit per
// architectural register blocks issue on RAW/WAW hazards until writeback.
//
// Handshakes (fetch->decode and decode->execute): a transfer happens on a
// rising edge where valid and ready are both high; once decode raises
// ex_valid the ex_* payload holds stable until ex_ready takes it.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [31:0]       if_instr,
   input  logic [XLEN-1:0]   if_pc,
   output logic [REG_AW-1:0] rs1_addr,
   output logic [REG_AW-1:0] rs2_addr,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_val,
   output logic [XLEN-1:0]   ex_rs2_val,
   output logic [31:0]       ex_imm,
   output logic [REG_AW-1:0] ex_rd,
   output logic [3:0]        ex_opclass,
   output logic [2:0]        ex_funct3,
   output logic              ex_funct7b5,
   output logic              ex_illegal,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              flush
);

   localparam int NREG = 1 << REG_AW;

   logic              id_valid;
   logic [31:0]       id_instr;
   logic [XLEN-1:0]   id_pc;
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_next;

   opclass_t          dec_oc;
   imm_fmt_t          dec_fmt;
   logic              dec_legal;
   logic [REG_AW-1:0] dec_rd;
   logic [31:0]       dec_imm;
   logic              need_rs1;
   logic              need_rs2;
   logic              need_rd;
   logic              hazard;
   logic              issue;

   assign rs1_addr = id_instr[19:15];
   assign rs2_addr = id_instr[24:20];
   assign dec_rd   = id_instr[11:7];

   // Classify the held instruction and pick its immediate format.
   always_comb begin
      dec_oc    = OC_OP;
      dec_fmt   = FMT_NONE;
      dec_legal = 1'b1;
      case (id_instr[6:0])
         OPC_OP:     dec_oc = OC_OP;
         OPC_OP_IMM: begin dec_oc = OC_OP_IMM; dec_fmt = FMT_I; end
         OPC_LOAD:   begin dec_oc = OC_LOAD;   dec_fmt = FMT_I; end
         OPC_STORE:  begin dec_oc = OC_STORE;  dec_fmt = FMT_S; end
         OPC_BRANCH: begin dec_oc = OC_BRANCH; dec_fmt = FMT_B; end
         OPC_JAL:    begin dec_oc = OC_JAL;    dec_fmt = FMT_J; end
         OPC_JALR:   begin dec_oc = OC_JALR;   dec_fmt = FMT_I; end
         OPC_LUI:    begin dec_oc = OC_LUI;    dec_fmt = FMT_U; end
         OPC_AUIPC:  begin dec_oc = OC_AUIPC;  dec_fmt = FMT_U; end
         default:    dec_legal = 1'b0;
      endcase
   end

   imm_gen u_imm_gen (
      .instr (id_instr[31:7]),
      .fmt   (dec_fmt),
      .imm   (dec_imm)
   );

   // Hazard check against the registered busy vector (no writeback bypass);
   // illegal instructions touch no registers so they never stall.
   always_comb begin
      need_rs1 = dec_legal & uses_rs1(dec_oc);
      need_rs2 = dec_legal & uses_rs2(dec_oc);
      need_rd  = dec_legal & writes_rd(dec_oc) & (dec_rd != '0);
      hazard   = (need_rs1 & busy[rs1_addr]) |
                 (need_rs2 & busy[rs2_addr]) |
                 (need_rd  & busy[dec_rd]);
      issue    = id_valid & ~hazard & (~ex_valid | ex_ready);
   end

   assign if_ready = ~id_valid | issue;

   // Scoreboard update: writeback clears, issue sets, set wins on a tie.
   always_comb begin
      busy_next = busy;
      if (wb_valid) busy_next[wb_rd] = 1'b0;
      if (issue && need_rd) busy_next[dec_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // ID register: refills whenever the slot is free or being vacated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (if_ready) begin
         id_valid <= if_valid;
         if (if_valid) begin
            id_instr <= if_instr;
            id_pc    <= if_pc;
         end
      end
   end

   // EX register: loads on issue, otherwise holds until execute accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_val  <= '0;
         ex_rs2_val  <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_opclass  <= '0;
         ex_funct3   <= '0;
         ex_funct7b5 <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (issue) begin
         ex_valid    <= 1'b1;
         ex_pc       <= id_pc;
         ex_rs1_val  <= rs1_data;
         ex_rs2_val  <= rs2_data;
         ex_imm      <= dec_imm;
         ex_rd       <= need_rd ? dec_rd : '0;
         ex_opclass  <= dec_legal ? dec_oc : OC_OP;
         ex_funct3   <= id_instr[14:12];
         ex_funct7b5 <= id_instr[30];
         ex_illegal  <= ~dec_legal;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

   // Busy vector register; a flush forgets every outstanding write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus a randomized stream,
// all bundles checked by a scoreboard fed from a behavioural decoder.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  oc;
      logic [2:0]  f3;
      logic        f7;
      logic        ill;
   } bundle_t;

   localparam int BW = $bits(bundle_t);

   // ---------------- clock / reset / DUT ----------------
   logic        clk;
   logic        rst_n;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs1_val;
   logic [31:0] ex_rs2_val;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic [3:0]  ex_opclass;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5;
   logic        ex_illegal;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        flush;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   decode_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_pc       (ex_pc),
      .ex_rs1_val  (ex_rs1_val),
      .ex_rs2_val  (ex_rs2_val),
      .ex_imm      (ex_imm),
      .ex_rd       (ex_rd),
      .ex_opclass  (ex_opclass),
      .ex_funct3   (ex_funct3),
      .ex_funct7b5 (ex_funct7b5),
      .ex_illegal  (ex_illegal),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .flush       (flush)
   );

   // Register bank model: constant contents, combinational read, x0 = 0.
   logic [31:0] regs [32];
   assign rs1_data = regs[rs1_addr];
   assign rs2_data = regs[rs2_addr];

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [BW-1:0] exp_q [$];
   logic [4:0]  wb_q [$];
   logic [4:0]  wb_manual_q [$];
   bit          auto_wb = 0;
   bit          rand_ready = 0;
   bit          ex_ready_force = 1;

   localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                      7'b0010111};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Behavioural decoder: RV32I field rules with plain arithmetic.
   function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
      bundle_t b;
      int      v;
      bit      wr;
      b     = '0;
      b.pc  = pc;
      b.rs1 = regs[w[19:15]];
      b.rs2 = regs[w[24:20]];
      b.f3  = w[14:12];
      b.f7  = w[30];
      wr    = 1'b0;
      v     = 0;
      case (w[6:0])
         7'b0110011: begin b.oc = 4'd0; wr = 1'b1; end
         7'b0010011, 7'b0000011, 7'b1100111: begin
            b.oc = (w[6:0] == 7'b0010011) ? 4'd1 : (w[6:0] == 7'b0000011) ? 4'd2 : 4'd6;
            wr   = 1'b1;
            v    = int'(w[31:20]);
            if (w[31]) v -= 4096;
            b.imm = 32'(v);
         end
         7'b0100011: begin
            b.oc = 4'd3;
            v    = int'({w[31:25], w[11:7]});
            if (w[31]) v -= 4096;
            b.imm = 32'(v);
         end
         7'b1100011: begin
            b.oc = 4'd4;
            v    = int'({w[31], w[7], w[30:25], w[11:8]}) * 2;
            if (w[31]) v -= 8192;
            b.imm = 32'(v);
         end
         7'b1101111: begin
            b.oc = 4'd5;
            wr   = 1'b1;
            v    = int'({w[31], w[19:12], w[20], w[30:21]}) * 2;
            if (w[31]) v -= 2097152;
            b.imm = 32'(v);
         end
         7'b0110111, 7'b0010111: begin
            b.oc  = (w[6:0] == 7'b0110111) ? 4'd7 : 4'd8;
            wr    = 1'b1;
            b.imm = w & 32'hFFFF_F000;
         end
         default: b.ill = 1'b1;
      endcase
      if (wr && (w[11:7] != 5'd0)) b.rd = w[11:7];
      return b;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w        = $urandom();
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0)
         w[6:0] = {5'($urandom_range(0, 31)), 2'b10};
      else
         w[6:0] = OPS[$urandom_range(0, 8)];
      return w;
   endfunction

   // ---------------- background drivers ----------------
   // Execute-side ready: forced by the directed tests or random.
   initial begin
      ex_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         ex_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ex_ready_force;
      end
   end

   // Writeback: manual requests first, else random retirement in order.
   initial begin
      wb_valid = 1'b0;
      wb_rd    = '0;
      forever begin
         @(posedge clk);
         #2;
         if (wb_manual_q.size() > 0) begin
            wb_valid = 1'b1;
            wb_rd    = wb_manual_q.pop_front();
         end else if (auto_wb && wb_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            wb_valid = 1'b1;
            wb_rd    = wb_q.pop_front();
         end else begin
            wb_valid = 1'b0;
         end
      end
   end

   // Monitor: every accepted execute bundle is popped and compared.
   always @(negedge clk) begin
      bundle_t a;
      bundle_t e;
      if (rst_n && ex_valid && ex_ready && !flush) begin
         a = '{pc: ex_pc, rs1: ex_rs1_val, rs2: ex_rs2_val, imm: ex_imm, rd: ex_rd,
               oc: ex_opclass, f3: ex_funct3, f7: ex_funct7b5, ill: ex_illegal};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ex_unexpected actual_pc=%h required=none", ex_pc);
         end else begin
            e = exp_q.pop_front();
            if (e.ill) a.imm = '0;
            if (a !== e) begin
               errors++;
               $display("FAIL ex_bundle actual=%h required=%h", a, e);
            end
            if (auto_wb && e.rd != 5'd0) wb_q.push_back(e.rd);
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] instr, input logic [31:0] pc, output int stalls);
      bit done;
      done     = 1'b0;
      stalls   = 0;
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
      while (!done) begin
         @(negedge clk);
         done = if_ready;
         tick();
         if (done) begin
            exp_q.push_back(ref_decode(instr, pc));
         end else begin
            stalls++;
            if (stalls > 500) begin
               checks++;
               errors++;
               $display("FAIL send_timeout actual=stalled required=accepted pc=%h", pc);
               done = 1'b1;
            end
         end
      end
      if_valid = 1'b0;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int st;
      rst_n    = 1'b0;
      if_valid = 1'b0;
      if_instr = '0;
      if_pc    = '0;
      flush    = 1'b0;
      regs[0]  = '0;
      for (int i = 1; i < 32; i++) regs[i] = $urandom();
      regs[1]  = 32'h100;
      regs[2]  = 32'hAB;

      // Reset state
      #12;
      check("rst_if_ready", 32'(if_ready), 32'd1);
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_rs1_addr", 32'(rs1_addr), 32'd0);
      check("rst_rs2_addr", 32'(rs2_addr), 32'd0);
      check("rst_ex_pc", ex_pc, 32'd0);
      check("rst_ex_imm", ex_imm, 32'd0);
      check("rst_busy", dut.busy, 32'd0);
      tick();
      rst_n = 1'b1;

      // addi x5,x0,7
      tick();
      send(32'h0070_0293, 32'h100, st);
      @(negedge clk);
      check("addi_rs1_addr", 32'(rs1_addr), 32'd0);
      check("addi_rs2_addr", 32'(rs2_addr), 32'd7);
      @(negedge clk);
      check("addi_ex_valid", 32'(ex_valid), 32'd1);
      check("addi_opclass", 32'(ex_opclass), 32'd1);
      check("addi_imm", ex_imm, 32'd7);
      check("addi_rd", 32'(ex_rd), 32'd5);
      check("addi_busy", dut.busy, 32'h0000_0020);
      wb_manual_q.push_back(5'd5);
      settle(3);
      check("addi_busy_cleared", dut.busy, 32'd0);

      // sw x2,-4(x1)
      send(32'hFE20_AE23, 32'h104, st);
      @(negedge clk);
      @(negedge clk);
      check("sw_imm", ex_imm, 32'hFFFF_FFFC);
      check("sw_rd", 32'(ex_rd), 32'd0);
      check("sw_rs1_val", ex_rs1_val, 32'h100);
      check("sw_rs2_val", ex_rs2_val, 32'hAB);
      check("sw_opclass", 32'(ex_opclass), 32'd3);
      check("sw_busy", dut.busy, 32'd0);

      // RAW: addi x5 then add x6,x5,x5
      tick();
      send(32'h0070_0293, 32'h200, st);
      send(32'h0052_8333, 32'h204, st);
      check("raw_add_accept_stalls", 32'(st), 32'd0);
      @(negedge clk);
      check("raw_stall_ready", 32'(if_ready), 32'd0);
      tick();
      @(negedge clk);
      check("raw_stall_ready2", 32'(if_ready), 32'd0);
      wb_manual_q.push_back(5'd5);
      @(negedge clk);
      check("raw_wb_no_bypass", 32'(if_ready), 32'd0);
      @(negedge clk);
      check("raw_release_ready", 32'(if_ready), 32'd1);
      check("raw_not_yet_issued", 32'(ex_valid), 32'd0);
      @(negedge clk);
      check("raw_issued", 32'(ex_valid), 32'd1);
      check("raw_ex_pc", ex_pc, 32'h204);
      check("raw_busy", dut.busy, 32'h0000_0040);
      wb_manual_q.push_back(5'd6);
      settle(3);
      check("raw_busy_cleared", dut.busy, 32'd0);

      // Backpressure with a 3-instruction stream
      ex_ready_force = 1'b0;
      tick();
      send(32'h0010_0393, 32'h300, st);
      send(32'h0020_0413, 32'h304, st);
      if_valid = 1'b1;
      if_instr = 32'h0030_0493;
      if_pc    = 32'h308;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_if_ready", 32'(if_ready), 32'd0);
         check("bp_ex_valid", 32'(ex_valid), 32'd1);
         check("bp_ex_pc", ex_pc, 32'h300);
         check("bp_ex_imm", ex_imm, 32'd1);
         check("bp_rs2_addr", 32'(rs2_addr), 32'd2);
         tick();
      end
      ex_ready_force = 1'b1;
      send(32'h0030_0493, 32'h308, st);
      check("bp_third_accept_stalls", 32'(st), 32'd0);
      @(negedge clk);
      check("bp_drain2_pc", ex_pc, 32'h304);
      @(negedge clk);
      check("bp_drain3_pc", ex_pc, 32'h308);
      check("bp_drain3_valid", 32'(ex_valid), 32'd1);
      wb_manual_q.push_back(5'd7);
      wb_manual_q.push_back(5'd8);
      wb_manual_q.push_back(5'd9);
      settle(6);
      check("bp_busy_cleared", dut.busy, 32'd0);

      // Illegal instruction followed by add x6,x0,x0
      send(32'hFFFF_FFFF, 32'h400, st);
      send(32'h0000_0333, 32'h404, st);
      check("ill_next_no_stall", 32'(st), 32'd0);
      @(negedge clk);
      check("ill_flag", 32'(ex_illegal), 32'd1);
      check("ill_rd", 32'(ex_rd), 32'd0);
      check("ill_opclass", 32'(ex_opclass), 32'd0);
      check("ill_busy", dut.busy, 32'd0);
      @(negedge clk);
      check("ill_add_pc", ex_pc, 32'h404);
      check("ill_add_legal", 32'(ex_illegal), 32'd0);
      wb_manual_q.push_back(5'd6);
      settle(3);

      // Flush mid-stall
      ex_ready_force = 1'b0;
      tick();
      send(32'h0070_0293, 32'h500, st);
      send(32'h0052_8333, 32'h504, st);
      @(negedge clk);
      check("fl_stalled", 32'(if_ready), 32'd0);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("fl_ex_valid", 32'(ex_valid), 32'd0);
      check("fl_if_ready", 32'(if_ready), 32'd1);
      check("fl_busy", dut.busy, 32'd0);

      // Asynchronous reset mid-stall
      tick();
      send(32'h0070_0293, 32'h600, st);
      send(32'h0052_8333, 32'h604, st);
      @(negedge clk);
      check("ar_stalled", 32'(if_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_ex_valid", 32'(ex_valid), 32'd0);
      check("ar_if_ready", 32'(if_ready), 32'd1);
      check("ar_busy", dut.busy, 32'd0);
      check("ar_rs1_addr", 32'(rs1_addr), 32'd0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      ex_ready_force = 1'b1;
      tick();

      // Randomized stream against the reference decoder
      rand_ready = 1'b1;
      auto_wb    = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) tick();
         send(rand_instr(), 32'h1000 + 32'(n) * 4, st);
      end
      for (int c = 0; c < 3000 && exp_q.size() > 0; c++) tick();
      check("rand_drain", 32'(exp_q.size()), 32'd0);
      for (int c = 0; c < 3000 && wb_q.size() > 0; c++) tick();
      settle(3);
      check("rand_busy_final", dut.busy, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the RV32I pipeline, directly upstream of `RegisterBank`. It accepts instructions from fetch over a valid/ready handshake and drives `rs1_addr`/`rs2_addr` to the register bank. It captures the combinational read data and registers a decoded bundle toward execute. A 32-entry busy scoreboard stalls issue on RAW/WAW hazards until writeback clears the destination.

## Interface
- `XLEN`, 32, datapath width (fixed at 32 for RV32I)
- `REG_AW`, 5, register address width
- `clk` in 1, rising-edge clock
- `rst_n` in 1, reset, asynchronous active-low
- `if_valid` in 1, fetch presents an instruction
- `if_ready` out 1, decode can accept this cycle
- `if_instr` in 32, instruction word
- `if_pc` in 32, instruction address
- `rs1_addr` out 5, `instr[19:15]` of the held instruction, to the register bank
- `rs2_addr` out 5, `instr[24:20]` of the held instruction
- `rs1_data` in 32, register bank read data (combinational, x0 reads 0)
- `rs2_data` in 32, register bank read data
- `ex_valid` out 1, execute bundle valid
- `ex_ready` in 1, execute accepts
- `ex_pc` out 32, PC of the issued instruction
- `ex_rs1_val` out 32, captured operand 1
- `ex_rs2_val` out 32, captured operand 2
- `ex_imm` out 32, sign-extended immediate
- `ex_rd` out 5, destination (0 if none)
- `ex_opclass` out 4, instruction class
- `ex_funct3` out 3, funct3 field
- `ex_funct7b5` out 1, `instr[30]`
- `ex_illegal` out 1, unsupported opcode
- `wb_valid` in 1, writeback retiring a result
- `wb_rd` in 5, destination being retired
- `flush` in 1, synchronous pipeline kill

## Operation
- ID register: `id_valid`, `id_instr`, `id_pc`. EX register: all `ex_*` outputs.
- Opclass encoding (all others are illegal):
  - OP = 0 (`0110011`), OP_IMM = 1 (`0010011`), LOAD = 2 (`0000011`), STORE = 3 (`0100011`), BRANCH = 4 (`1100011`)
  - JAL = 5 (`1101111`), JALR = 6 (`1100111`), LUI = 7 (`0110111`), AUIPC = 8 (`0010111`)
- Illegal instruction: `ex_illegal` = 1, `ex_opclass` = 0, `ex_rd` = 0. It performs no hazard check and sets no busy bit.
- Immediate formats per RV32I:
  - I-type: OP_IMM, LOAD, JALR
  - S-type: STORE
  - B-type: BRANCH
  - U-type: LUI, AUIPC
  - J-type: JAL
  - OP gives `ex_imm` = 0.
- Register usage:
  - uses_rs1: OP, OP_IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2: OP, STORE, BRANCH.
  - writes_rd: OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC, and only when rd ≠ 0. Otherwise `ex_rd` = 0.
- Hazard (stall) when any of the following hold. Register 0 is never busy.
  - `busy[rs1]` and uses_rs1
  - `busy[rs2]` and uses_rs2
  - `busy[rd]` and writes_rd
- `issue = id_valid & !hazard & (!ex_valid | ex_ready)`.
- `if_ready = !id_valid | issue` (combinational).
- On issue:
  - EX register loads the decoded fields plus `rs1_data`/`rs2_data` sampled that cycle.
  - `ex_valid` is set to 1.
  - `busy[rd]` is set if writes_rd.
- `ex_valid` clears when `ex_ready & !issue`.
- Scoreboard:
  - `wb_valid` clears `busy[wb_rd]`.
  - If the same register is set and cleared in one cycle, set wins.
  - No bypass: the hazard check uses the registered busy vector, so a clear takes effect for issue one cycle later.
- Flush: clears `id_valid`, `ex_valid`, and the entire busy vector. `wb_valid` in the same cycle is ignored. `if_ready` is 1 in the cycle after a flush.

## Timing
- Reset (async, on `rst_n` = 0):
  - `id_valid` = 0, `id_instr` = 0, `id_pc` = 0, busy = 0.
  - All `ex_*` = 0, including `ex_valid`.
  - Therefore `rs1_addr` = `rs2_addr` = 0 and `if_ready` = 1.
- Latency: instruction accepted at edge N, decoded/read in cycle N+1, `ex_valid` = 1 after edge N+1.
- Throughput: 1 instruction per cycle with no hazard and `ex_ready` = 1.
- Backpressure: while `ex_valid & !ex_ready`, all `ex_*` hold stable. `if_ready` drops once ID is occupied.
- Stalled ID: the ID register holds, and `rs*_addr` stay constant.
- Minimum RAW stall: `wb_valid` clears the bit at edge W; the dependent instruction issues at edge W+1.

## Structure
- Package `decode_pkg` holds:
  - opcode localparams
  - opclass enum (4-bit)
  - immediate-format enum
  - function `uses_rs1`/`uses_rs2`/`writes_rd` helpers
- Sub-module `imm_gen`: combinational, takes instr and format, returns the 32-bit immediate.
- The scoreboard and handshake logic stay inline.

## Test plan
- `addi x5,x0,7` (`0x00700293`):
  - `rs1_addr` = 0 during decode.
  - Next cycle: `ex_opclass` = 1, `ex_imm` = 7, `ex_rd` = 5, `busy[5]` = 1.
- `sw x2,-4(x1)` (`0xFE20AE23`) with `rs1_data` = `0x100` and `rs2_data` = `0xAB`:
  - `ex_imm` = `0xFFFFFFFC`, `ex_rd` = 0, `ex_rs1_val` = `0x100`, `ex_rs2_val` = `0xAB`, `ex_opclass` = 3.
- `addi x5` followed by `add x6,x5,x5` (`0x00528333`):
  - The add stalls with `if_ready` = 0.
  - Pulse `wb_valid` with `wb_rd` = 5 at edge W: the add issues at edge W+1 and `busy[6]` = 1.
- Hold `ex_ready` = 0 for 3 cycles with a stream of 3 instructions:
  - `ex_*` stay stable, the second instruction is held in ID, and the third sees `if_ready` = 0.
  - Releasing `ex_ready` drains the stream in order, one per cycle.
- `0xFFFFFFFF`: `ex_illegal` = 1, `ex_rd` = 0, no busy bit set. A following `add x6,x0,x0` issues without stall.
- Flush or `rst_n` low mid-stall:
  - `ex_valid` = 0, busy = 0, and `if_ready` = 1 on the next cycle.
  - Async reset takes effect without a clock edge.
